// File: rtl/booth2.sv
// booth2: radix-4 Booth partial-product generator, one registered stage.
// Optional zero-flag output enabled by defining BOOTH2_ZERO_FLAG_EN.
module booth2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        x2,
    input  logic        x1,
    input  logic        x0,
    input  logic [15:0] y,
`ifdef BOOTH2_ZERO_FLAG_EN
    output logic        zero,
`endif
    output logic        out_valid,
    output logic [16:0] y_pro,
    output logic        s,
    output logic        e
);

    logic [2:0]  trip;
    logic [16:0] pp_nxt;
    logic        s_nxt;
    logic        z_nxt;

    assign trip = {x2, x1, x0};

    always_comb begin
        pp_nxt = 17'h00000;
        s_nxt  = 1'b0;
        z_nxt  = 1'b0;
        case (trip)
            3'b001, 3'b010: pp_nxt = {y[15], y};
            3'b011:         pp_nxt = {y, 1'b0};
            3'b100: begin
                pp_nxt = ~{y, 1'b0};
                s_nxt  = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_nxt = ~{y[15], y};
                s_nxt  = 1'b1;
            end
            default: z_nxt = 1'b1;
        endcase
`ifdef BOOTH2_ZERO_FLAG_EN
        // A zero multiplicand forces a true zero, never a negated one
        if (y == 16'h0000)
            z_nxt = 1'b1;
        if (z_nxt) begin
            pp_nxt = 17'h00000;
            s_nxt  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y_pro     <= 17'h00000;
            s         <= 1'b0;
            e         <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_pro <= pp_nxt;
                s     <= s_nxt;
                e     <= ~pp_nxt[16];
            end
        end
    end

`ifdef BOOTH2_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            zero <= 1'b0;
        else if (in_valid)
            zero <= z_nxt;
    end
`else
    logic unused_z;
    assign unused_z = z_nxt;
`endif

endmodule

// File: tb/tb_booth2.sv
// tb_booth2: scoreboard bench for booth2.
// Build with BOOTH2_ZERO_FLAG_EN defined to cover the zero output.
module tb_booth2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        x2, x1, x0;
    logic [15:0] y;
    logic        out_valid;
    logic [16:0] y_pro;
    logic        s;
    logic        e;
    logic        zero;

    typedef struct {
        logic [16:0] pp;
        logic        s;
        logic        e;
        logic        z;
        logic [16:0] val;
    } exp_t;

    exp_t q[$];
    int   n_chk;
    int   n_fail;

    logic [16:0] hp;
    logic        hs, he, hz;

    booth2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x2        (x2),
        .x1        (x1),
        .x0        (x0),
        .y         (y),
`ifdef BOOTH2_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .out_valid (out_valid),
        .y_pro     (y_pro),
        .s         (s),
        .e         (e)
    );

`ifndef BOOTH2_ZERO_FLAG_EN
    assign zero = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed multiple m in {-2..2}, result taken mod 2^17
    function automatic exp_t model(input logic [2:0] t, input logic [15:0] yy);
        exp_t r;
        int m;
        int v;
        logic [16:0] mag;
        m = -2 * int'(t[2]) + int'(t[1]) + int'(t[0]);
        v = m * int'($signed(yy));
        r.val = v[16:0];
        r.z = (m == 0);
        if (m < 0) begin
            mag  = 17'(-v);
            r.pp = ~mag;
            r.s  = 1'b1;
        end else begin
            r.pp = v[16:0];
            r.s  = 1'b0;
        end
`ifdef BOOTH2_ZERO_FLAG_EN
        if (yy == 16'h0000) r.z = 1'b1;
        if (r.z) begin
            r.pp = 17'h0;
            r.s  = 1'b0;
        end
`endif
        r.e = ~r.pp[16];
        return r;
    endfunction

    function automatic exp_t lit(input logic [2:0] t, input logic [15:0] yy,
                                 input logic [16:0] pp, input logic ss,
                                 input logic ee);
        exp_t r;
        r    = model(t, yy);
        r.pp = pp;
        r.s  = ss;
        r.e  = ee;
        return r;
    endfunction

    task automatic compare(input logic exp_v);
        exp_t ex;
        check("out_valid", 32'(out_valid), 32'(exp_v));
        if (exp_v) begin
            if (q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                ex = q.pop_front();
                hp = ex.pp;
                hs = ex.s;
                he = ex.e;
                hz = ex.z;
                check("pp_plus_s", 32'(17'(y_pro + 17'(s))), 32'(ex.val));
            end
        end else if (!rst_n) begin
            hp = 17'h0;
            hs = 1'b0;
            he = 1'b0;
            hz = 1'b0;
        end
        check("y_pro", 32'(y_pro), 32'(hp));
        check("s", 32'(s), 32'(hs));
        check("e", 32'(e), 32'(he));
`ifdef BOOTH2_ZERO_FLAG_EN
        check("zero", 32'(zero), 32'(hz));
`endif
    endtask

    task automatic step(input logic iv, input logic [2:0] t,
                        input logic [15:0] yy, input exp_t ex);
        logic v;
        in_valid     = iv;
        {x2, x1, x0} = t;
        y            = yy;
        v            = iv && rst_n;
        if (v) q.push_back(ex);
        @(posedge clk);
        #1;
        compare(v);
    endtask

    task automatic step_m(input logic iv, input logic [2:0] t,
                          input logic [15:0] yy);
        step(iv, t, yy, model(t, yy));
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        hp       = 17'h0;
        hs       = 1'b0;
        he       = 1'b0;
        hz       = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        {x2, x1, x0} = 3'b011;
        y        = 16'h4d6f;

        // Reset held with in_valid high: reset must win
        step_m(1'b1, 3'b011, 16'h4d6f);
        step_m(1'b1, 3'b101, 16'h1234);
        rst_n = 1'b1;

        // Directed vectors with literal expectations
        step(1'b1, 3'b001, 16'h4d6f, lit(3'b001, 16'h4d6f, 17'h04d6f, 1'b0, 1'b1));
        step(1'b1, 3'b010, 16'h4d6f, lit(3'b010, 16'h4d6f, 17'h04d6f, 1'b0, 1'b1));
        step(1'b1, 3'b011, 16'h4d6f, lit(3'b011, 16'h4d6f, 17'h09ade, 1'b0, 1'b1));
        step(1'b1, 3'b101, 16'h4d6f, lit(3'b101, 16'h4d6f, 17'h1b290, 1'b1, 1'b0));
        step(1'b1, 3'b110, 16'h4d6f, lit(3'b110, 16'h4d6f, 17'h1b290, 1'b1, 1'b0));
        step(1'b1, 3'b100, 16'h4d6f, lit(3'b100, 16'h4d6f, 17'h16521, 1'b1, 1'b0));
        step(1'b1, 3'b000, 16'h4d6f, lit(3'b000, 16'h4d6f, 17'h00000, 1'b0, 1'b1));
        step(1'b1, 3'b111, 16'h4d6f, lit(3'b111, 16'h4d6f, 17'h00000, 1'b0, 1'b1));
        step(1'b1, 3'b001, 16'h8000, lit(3'b001, 16'h8000, 17'h18000, 1'b0, 1'b0));
        step(1'b1, 3'b100, 16'h8000, lit(3'b100, 16'h8000, 17'h0ffff, 1'b1, 1'b1));
`ifdef BOOTH2_ZERO_FLAG_EN
        step(1'b1, 3'b101, 16'h0000, lit(3'b101, 16'h0000, 17'h00000, 1'b0, 1'b1));
`else
        step(1'b1, 3'b101, 16'h0000, lit(3'b101, 16'h0000, 17'h1ffff, 1'b1, 1'b0));
`endif

        // Back-to-back sweep of all triplets, wrapping 111 -> 000
        for (int i = 0; i < 9; i++)
            step_m(1'b1, 3'(i % 8), 16'h4d6f);

        // Hold: inputs change while in_valid is low
        for (int i = 0; i < 4; i++)
            step_m(1'b0, 3'($urandom_range(0, 7)), 16'($urandom));

        // Random mix of valid and idle cycles
        for (int i = 0; i < 64; i++)
            step_m(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                   16'($urandom));

        // Mid-stream reset clears held state
        rst_n = 1'b0;
        step_m(1'b1, 3'b011, 16'h7fff);
        rst_n = 1'b1;
        step_m(1'b0, 3'b011, 16'h7fff);
        step_m(1'b1, 3'b011, 16'h7fff);

        check("sb_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
